// File: rtl/interrupt_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state, defaults
// and a lowest-index-wins priority encoder.
package interrupt_pkg;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} irq_state_e;

  localparam int N_CH_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;

  typedef struct packed {
    logic       any;
    logic [4:0] idx;
  } prio_t;

  // Scans from the top down so the lowest set bit is the last one written.
  function automatic prio_t prio_enc(input logic [31:0] req);
    prio_t r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) begin
        r.any = 1'b1;
        r.idx = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-channel synchroniser chain plus a history flop; emits a one-cycle pulse
// on each synchronised rising edge.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic async_i,
  output logic evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History clears with the chain, so a line held high across reset fires once.
  assign evt_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/interrupt_controller.sv
// Sticky-pending, maskable, fixed-priority interrupt controller presenting a
// single registered Irq/Irq_Id pair to the CPU with an Ack handshake.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [N_CH-1:0] Sw,
  input  logic [N_CH-1:0] Mask_In,
  input  logic            Mask_Write,
  input  logic            Ack,
  output logic            Irq,
  output logic [ID_W-1:0] Irq_Id,
  output logic [N_CH-1:0] Pending,
  output logic [N_CH-1:0] Mask
);

  logic [N_CH-1:0] evt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLK     (CLK),
      .CLR     (CLR),
      .async_i (Sw[g]),
      .evt_o   (evt[g])
    );
  end

  irq_state_e      state_q, state_d;
  logic [N_CH-1:0] pend_q, pend_d, mask_q, mask_d, clr_vec;
  logic            irq_q, irq_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     req;
  prio_t           enc;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mask_q  <= '1;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    req             = '0;
    req[N_CH-1:0]   = pend_q & mask_q;
    enc             = prio_enc(req);
    state_d         = state_q;
    irq_d           = irq_q;
    id_d            = id_q;
    clr_vec         = '0;
    case (state_q)
      IDLE: begin
        if (enc.any) begin
          state_d = ACTIVE;
          irq_d   = 1'b1;
          id_d    = enc.idx[ID_W-1:0];
        end
      end
      ACTIVE: begin
        // Request is locked until acknowledged; no preemption or withdrawal.
        if (Ack) begin
          state_d = IDLE;
          irq_d   = 1'b0;
          clr_vec = N_CH'(1) << id_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // OR-ing the event after the clear keeps a coincident new edge pending.
    pend_d = (pend_q & ~clr_vec) | evt;
    mask_d = Mask_Write ? Mask_In : mask_q;
  end

  assign Irq     = irq_q;
  assign Irq_Id  = id_q;
  assign Pending = pend_q;
  assign Mask    = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized bench for interrupt_controller checked against a sample-history
// reference model of the controller's documented behaviour.
module tb_interrupt_controller;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          CLK = 1'b0;
  logic          CLR;
  logic [N-1:0]  Sw, Mask_In;
  logic          Mask_Write, Ack;
  logic          Irq;
  logic [IW-1:0] Irq_Id;
  logic [N-1:0]  Pending, Mask;

  int total = 0;
  int bad   = 0;

  interrupt_controller #(.N_CH(N), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .CLR(CLR), .Sw(Sw), .Mask_In(Mask_In), .Mask_Write(Mask_Write),
    .Ack(Ack), .Irq(Irq), .Irq_Id(Irq_Id), .Pending(Pending), .Mask(Mask)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state; h[d] is the Sw sample taken d+1 edges ago.
  logic [N-1:0]  m_pend, m_mask;
  logic          m_irq;
  logic [IW-1:0] m_id;
  logic [N-1:0]  h [3];

  task automatic model_edge();
    logic [N-1:0] ev, av;
    if (CLR) begin
      m_pend = '0; m_mask = '1; m_irq = 1'b0; m_id = '0;
      for (int i = 0; i < 3; i++) h[i] = '0;
    end else begin
      ev = h[1] & ~h[2];
      av = m_pend & m_mask;
      if (m_irq) begin
        if (Ack) begin
          m_pend[m_id] = 1'b0;
          m_irq = 1'b0;
        end
      end else if (av != 0) begin
        for (int i = N - 1; i >= 0; i--)
          if (av[i]) m_id = IW'(i);
        m_irq = 1'b1;
      end
      m_pend = m_pend | ev;
      if (Mask_Write) m_mask = Mask_In;
      h[2] = h[1]; h[1] = h[0]; h[0] = Sw;
    end
  endtask

  task automatic step_and_check();
    @(posedge CLK);
    model_edge();
    #1;
    chk("irq",     32'(Irq),     32'(m_irq));
    chk("irq_id",  32'(Irq_Id),  32'(m_id));
    chk("pending", 32'(Pending), 32'(m_pend));
    chk("mask",    32'(Mask),    32'(m_mask));
  endtask

  initial begin
    CLR = 1'b1; Sw = '0; Mask_In = '0; Mask_Write = 1'b0; Ack = 1'b0;
    m_pend = '0; m_mask = '0; m_irq = 1'b0; m_id = '0;
    for (int i = 0; i < 3; i++) h[i] = '0;
    // Hold lines high through reset to exercise the one-shot-after-reset case.
    Sw = 4'b0110;
    step_and_check();
    step_and_check();
    CLR = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      step_and_check();
      if ($urandom_range(3, 0) == 0) Sw[$urandom_range(N - 1, 0)] ^= 1'b1;
      Ack        = m_irq ? ($urandom_range(2, 0) == 0) : ($urandom_range(7, 0) == 0);
      Mask_Write = ($urandom_range(15, 0) == 0);
      Mask_In    = ($urandom_range(1, 0) == 0) ? 4'hF : N'($urandom);
      CLR        = ($urandom_range(249, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
